// File: rtl/copy_engine_arbiter_if.sv
// Handshake bundle between the draw clients, the copy engine and copy_engine_arbiter.
// The arbiter takes the master modport; clients and the engine model take the slave modport.
interface copy_engine_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0] req;
    logic             hold;
    logic             finished;
    logic             clear_err;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             copy_start;
    logic             copy_enable;
    logic [N_REQ-1:0] done;
    logic             busy;
    logic             timeout_err;
    logic [ID_W-1:0]  err_id;

    modport master (
        input  req, hold, finished, clear_err,
        output grant, grant_id, copy_start, copy_enable, done, busy, timeout_err, err_id
    );

    modport slave (
        output req, hold, finished, clear_err,
        input  grant, grant_id, copy_start, copy_enable, done, busy, timeout_err, err_id
    );
endinterface

// File: rtl/copy_engine_arbiter.sv
// Round-robin owner of the shared background/sprite copy engine: grants one draw client at a
// time, pulses copy_start, waits for finished (or aborts on timeout) and pulses done back.
module copy_engine_arbiter #(
    parameter int               N_REQ   = 4,
    parameter int               ID_W    = 2,
    parameter int               TO_W    = 20,
    parameter logic [TO_W-1:0]  TIMEOUT = 20'd833333
) (
    input  logic                   clock,
    input  logic                   reset,
    copy_engine_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_W'(1);

    // Search starts just after the last winner so a requester that keeps req high goes to the back.
    function automatic logic [ID_W-1:0] pick_winner(input logic [N_REQ-1:0] r,
                                                    input logic [ID_W-1:0]  p);
        logic [ID_W-1:0] w;
        logic [ID_W-1:0] idx;
        logic            found;
        w     = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = ID_W'((int'(p) + i) % N_REQ);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    state_t           state_p0, state_p1;
    logic [ID_W-1:0]  ptr_p0, ptr_p1;
    logic [TO_W-1:0]  cnt_p0, cnt_p1;
    logic [N_REQ-1:0] grant_p0, grant_p1;
    logic [ID_W-1:0]  gid_p0, gid_p1;
    logic [N_REQ-1:0] done_p0, done_p1;
    logic             err_p0, err_p1;
    logic [ID_W-1:0]  eid_p0, eid_p1;
    logic             start_p1, enable_p1, busy_p1;
    logic [ID_W-1:0]  winner;

    assign winner = pick_winner(bus.req, ptr_p1);

    // Stage p0: next-state and next-output decode
    always_comb begin
        state_p0 = state_p1;
        ptr_p0   = ptr_p1;
        cnt_p0   = cnt_p1;
        grant_p0 = grant_p1;
        gid_p0   = gid_p1;
        done_p0  = '0;
        err_p0   = err_p1 & ~bus.clear_err;
        eid_p0   = eid_p1;

        case (state_p1)
            IDLE: begin
                if (!bus.hold && (bus.req != '0)) begin
                    grant_p0 = onehot(winner);
                    gid_p0   = winner;
                    ptr_p0   = winner;
                    state_p0 = START;
                end
            end
            START: begin
                cnt_p0   = '0;
                state_p0 = BUSY;
            end
            BUSY: begin
                cnt_p0 = cnt_p1 + TO_W'(1);
                if (bus.finished) begin
                    done_p0  = onehot(gid_p1);
                    grant_p0 = '0;
                    state_p0 = RELEASE;
                end else if (cnt_p1 == TO_LAST) begin
                    // An abort sets the flag even when clear_err is high in the same cycle.
                    err_p0   = 1'b1;
                    eid_p0   = gid_p1;
                    done_p0  = onehot(gid_p1);
                    grant_p0 = '0;
                    state_p0 = RELEASE;
                end
            end
            RELEASE: begin
                state_p0 = IDLE;
            end
            default: begin
                state_p0 = IDLE;
            end
        endcase
    end

    // Stage p1: every output comes straight from a flop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_p1  <= IDLE;
            ptr_p1    <= ID_W'(N_REQ - 1);
            cnt_p1    <= '0;
            grant_p1  <= '0;
            gid_p1    <= '0;
            done_p1   <= '0;
            err_p1    <= 1'b0;
            eid_p1    <= '0;
            start_p1  <= 1'b0;
            enable_p1 <= 1'b0;
            busy_p1   <= 1'b0;
        end else begin
            state_p1  <= state_p0;
            ptr_p1    <= ptr_p0;
            cnt_p1    <= cnt_p0;
            grant_p1  <= grant_p0;
            gid_p1    <= gid_p0;
            done_p1   <= done_p0;
            err_p1    <= err_p0;
            eid_p1    <= eid_p0;
            start_p1  <= (state_p0 == START);
            enable_p1 <= (state_p0 == START) || (state_p0 == BUSY);
            busy_p1   <= (state_p0 != IDLE);
        end
    end

    assign bus.grant       = grant_p1;
    assign bus.grant_id    = gid_p1;
    assign bus.copy_start  = start_p1;
    assign bus.copy_enable = enable_p1;
    assign bus.done        = done_p1;
    assign bus.busy        = busy_p1;
    assign bus.timeout_err = err_p1;
    assign bus.err_id      = eid_p1;

endmodule

// File: tb/tb_copy_engine_arbiter.sv
// Directed bench for copy_engine_arbiter: stimulus queues expected grants and done pulses,
// a negedge monitor pops and compares them whenever copy_start or done appears.
module tb_copy_engine_arbiter;

    logic clock;
    logic reset;

    copy_engine_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();

    copy_engine_arbiter #(
        .N_REQ   (4),
        .ID_W    (2),
        .TO_W    (20),
        .TIMEOUT (20'd16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] done;
        logic       err;
        logic [1:0] eid;
    } done_exp_t;

    int        tests = 0;
    int        fails = 0;
    int        gq[$];
    done_exp_t dq[$];
    logic       exp_err;
    logic [1:0] exp_eid;

    function automatic logic [3:0] oh(input int id);
        logic [3:0] v;
        v = '0;
        v[id[1:0]] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_start();
        for (int n = 0; n < 40; n++) begin
            step();
            if (bus.copy_start) return;
        end
        tests++;
        fails++;
        $display("FAIL wait_copy_start: got no copy_start within 40 cycles expected one");
    endtask

    task automatic finish_after(input int n, input int id);
        done_exp_t e;
        repeat (n) step();
        bus.finished = 1'b1;
        e.done = oh(id);
        e.err  = exp_err;
        e.eid  = exp_eid;
        dq.push_back(e);
        step();
        bus.finished = 1'b0;
    endtask

    // Monitor
    int         mon_g;
    done_exp_t  mon_d;
    logic [3:0] prev_done;

    always @(negedge clock) begin
        if (reset) begin
            prev_done = '0;
        end else begin
            if (bus.copy_start) begin
                tests++;
                if (gq.size() == 0) begin
                    fails++;
                    $display("FAIL grant_unexpected: got grant %b expected no grant", bus.grant);
                end else begin
                    mon_g = gq.pop_front();
                    if (bus.grant !== oh(mon_g) || bus.grant_id !== 2'(mon_g)) begin
                        fails++;
                        $display("FAIL grant_order: got grant %b id %0d expected grant %b id %0d",
                                 bus.grant, bus.grant_id, oh(mon_g), mon_g);
                    end
                end
            end
            if (bus.done != '0) begin
                tests++;
                if (dq.size() == 0) begin
                    fails++;
                    $display("FAIL done_unexpected: got done %b expected none", bus.done);
                end else begin
                    mon_d = dq.pop_front();
                    if (bus.done !== mon_d.done || bus.timeout_err !== mon_d.err ||
                        bus.err_id !== mon_d.eid || bus.grant !== 4'b0000) begin
                        fails++;
                        $display("FAIL done_pulse: got done %b err %b eid %0d grant %b expected done %b err %b eid %0d grant 0000",
                                 bus.done, bus.timeout_err, bus.err_id, bus.grant,
                                 mon_d.done, mon_d.err, mon_d.eid);
                    end
                end
                tests++;
                if (prev_done != '0) begin
                    fails++;
                    $display("FAIL done_width: got done high two cycles (%b then %b) expected one", prev_done, bus.done);
                end
            end
            prev_done = bus.done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog");
    end

    int bad;

    initial begin
        reset         = 1'b1;
        bus.req       = '0;
        bus.hold      = 1'b0;
        bus.finished  = 1'b0;
        bus.clear_err = 1'b0;
        exp_err       = 1'b0;
        exp_eid       = 2'd0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Asynchronous reset in the middle of a transfer
        gq.push_back(0);
        bus.req = 4'b0001;
        wait_start();
        bus.req = '0;
        step();
        step();
        chk("pre_reset_busy", bus.busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_grant", bus.grant, 0);
        chk("rst_grant_id", bus.grant_id, 0);
        chk("rst_copy_start", bus.copy_start, 0);
        chk("rst_copy_enable", bus.copy_enable, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        chk("rst_err_id", bus.err_id, 0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Round robin with all requesters pending
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) gq.push_back(i % 4);
        for (int i = 0; i < 5; i++) begin
            wait_start();
            if (i == 4) bus.req = '0;
            finish_after(2, i % 4);
        end
        step();
        step();
        chk("rr_idle_after", bus.busy, 0);

        // hold blocks new grants
        bus.hold = 1'b1;
        bus.req  = 4'b0100;
        gq.push_back(2);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.grant != '0 || bus.busy) bad++;
        end
        chk("hold_no_grant_cycles", bad, 0);
        bus.hold = 1'b0;
        step();
        chk("hold_release_grant", bus.grant, 4'b0100);
        chk("hold_release_id", bus.grant_id, 2);
        bus.req = '0;
        finish_after(2, 2);
        step();
        step();

        // Timeout abort on requester 3
        bus.req = 4'b1000;
        gq.push_back(3);
        wait_start();
        bus.req = '0;
        dq.push_back('{done: 4'b1000, err: 1'b1, eid: 2'd3});
        repeat (16) step();
        chk("to_not_yet_err", bus.timeout_err, 0);
        chk("to_not_yet_done", bus.done, 0);
        step();
        chk("to_err", bus.timeout_err, 1);
        chk("to_err_id", bus.err_id, 3);
        chk("to_done", bus.done, 4'b1000);
        step();
        bus.clear_err = 1'b1;
        step();
        bus.clear_err = 1'b0;
        chk("clear_err_flag", bus.timeout_err, 0);
        chk("clear_err_keeps_id", bus.err_id, 3);
        exp_eid = 2'd3;

        // finished on the last allowed BUSY cycle wins over the timeout
        bus.req = 4'b0001;
        gq.push_back(0);
        wait_start();
        bus.req = '0;
        finish_after(16, 0);
        step();
        chk("finish_wins_no_err", bus.timeout_err, 0);
        step();

        // clear_err coinciding with an abort
        bus.req = 4'b0010;
        gq.push_back(1);
        wait_start();
        bus.req = '0;
        dq.push_back('{done: 4'b0010, err: 1'b1, eid: 2'd1});
        repeat (16) step();
        bus.clear_err = 1'b1;
        step();
        bus.clear_err = 1'b0;
        chk("set_wins_err", bus.timeout_err, 1);
        chk("set_wins_err_id", bus.err_id, 1);
        step();
        bus.clear_err = 1'b1;
        step();
        bus.clear_err = 1'b0;
        chk("clear_after_set", bus.timeout_err, 0);
        exp_err = 1'b0;
        exp_eid = 2'd1;

        // Stray finished in IDLE, then in START
        bus.finished = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.busy || bus.done != '0 || bus.grant != '0) bad++;
        end
        bus.finished = 1'b0;
        chk("stray_idle", bad, 0);
        bus.req = 4'b0100;
        gq.push_back(2);
        wait_start();
        bus.finished = 1'b1;
        step();
        bus.finished = 1'b0;
        chk("stray_start_done", bus.done, 0);
        chk("stray_start_busy", bus.busy, 1);
        chk("stray_start_enable", bus.copy_enable, 1);
        chk("stray_start_grant", bus.grant, 4'b0100);
        bus.req = '0;
        finish_after(3, 2);
        step();
        step();
        chk("drop_req_idle", bus.busy, 0);
        repeat (3) step();
        chk("drop_req_no_regrant", bus.grant, 0);

        chk("grant_queue_drained", gq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/copy_engine_arbiter.md
# copy_engine_arbiter

- Shares the single background/sprite copy engine between up to N_REQ draw requesters, e.g. tile drawer, player 1 sprite, player 2 sprite and bomb/explosion drawer.
- Sits between the game control FSM's draw clients and the copy engine.
- Arbitrates round-robin, sequences each transfer with a start pulse and a done pulse, and aborts any transfer whose engine never reports `finished`.

## Interface
- `N_REQ`, default 4: number of requesters.
- `ID_W`, default 2: width of the requester index; equals clog2(N_REQ).
- `TO_W`, default 20: width of the timeout counter.
- `TIMEOUT`, default 20'd833333: number of BUSY cycles allowed before a transfer is aborted.

Ports:
- `clock`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-high.
- `req`  in  N_REQ  level request, one bit per requester.
- `hold`  in  1  when 1, blocks new grants; a transfer already in flight is unaffected.
- `finished`  in  1  copy engine completion, one-cycle pulse.
- `clear_err`  in  1  clears `timeout_err`.
- `grant`  out  N_REQ  registered, one-hot or zero.
- `grant_id`  out  ID_W  index of the current or last granted requester.
- `copy_start`  out  1  one-cycle engine start pulse.
- `copy_enable`  out  1  high while a transfer owns the engine.
- `done`  out  N_REQ  one-cycle completion pulse to the granted requester.
- `busy`  out  1  high in every state other than IDLE.
- `timeout_err`  out  1  sticky abort flag.
- `err_id`  out  ID_W  requester index of the most recent abort.

## Operation
- FSM states are IDLE, START, BUSY and RELEASE.
- **IDLE**
  - If `hold`=0 and `req`≠0, select the winner by searching from index ptr+1 upward, wrapping modulo N_REQ.
  - Load `grant` (one-hot), `grant_id` and ptr with the winner, then go to START.
  - If `hold`=1 or `req`=0, stay in IDLE.
- **START**
  - `copy_start`=1 and `copy_enable`=1.
  - Clear the timeout counter and go to BUSY.
  - `finished` is ignored in this state.
- **BUSY**
  - `copy_enable`=1; the counter increments every cycle.
  - If `finished`=1: pulse `done[grant_id]`, clear `grant`, go to RELEASE.
  - Else if the counter equals TIMEOUT-1: set `timeout_err`, set `err_id`=`grant_id`, pulse `done[grant_id]`, clear `grant`, go to RELEASE.
- **RELEASE**
  - `done` is high during this cycle.
  - Go to IDLE unconditionally. This gives requesters one cycle to drop `req` before it is resampled.
- **Boundary rules**
  - Dropping `req` mid-transfer does not abort the transfer; it runs to `finished` or to timeout.
  - `finished` in IDLE, START or RELEASE is ignored.
  - If `finished` and the timeout condition occur in the same cycle, `finished` wins and no error is raised.
  - If `clear_err` and a new abort occur in the same cycle, the set wins: `timeout_err` stays 1.
  - `err_id` holds its value until the next abort; `clear_err` does not change it.
  - A requester that still holds `req` after its `done` is granted again only after every other pending requester has been served (round-robin fairness).
- **Reset** (asynchronous, any state, including mid-transfer)
  - State goes to IDLE; ptr = N_REQ-1, so index 0 has first priority.
  - `grant`=0, `grant_id`=0, `copy_start`=0, `copy_enable`=0, `done`=0, `busy`=0, `timeout_err`=0, `err_id`=0, counter=0.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- **Request to grant:** `req` sampled at edge k in IDLE gives `grant`/`grant_id`/`busy` valid after edge k, with `copy_start` high for the cycle k to k+1.
- **Completion:** `finished` sampled at edge m in BUSY gives `grant`=0 and `done` high for the cycle m to m+1. The FSM is in IDLE after edge m+1.
- **Minimum period:** 4 cycles per grant (IDLE, START, BUSY, RELEASE) when `finished` arrives in the first BUSY cycle.
- **Timeout:** the abort occurs on the TIMEOUT-th BUSY cycle without `finished`, which is TIMEOUT+1 cycles after `copy_start`.
- The timeout counter is TO_W bits, saturates logic-free (it is cleared before it can wrap), and is compared unsigned.

## Test plan
- **Reset values:** assert `reset` mid-BUSY → all outputs 0 immediately, with no clock edge required. After release, `req`=4'b1111 → `grant`=4'b0001.
- **Round-robin:** hold `req`=4'b1111 with `finished` returned 2 cycles after each `copy_start` → grant order 0,1,2,3,0, and each `done` pulse is exactly 1 cycle wide.
- **hold:** `hold`=1 with `req`=4'b0100 → no grant for 10 cycles. Drop `hold` → `grant`=4'b0100 and `grant_id`=2 one edge later.
- **Timeout:** set TIMEOUT=16, grant requester 3, never assert `finished` → on the 16th BUSY cycle `timeout_err`=1, `err_id`=3, `done[3]` pulses. Then assert `clear_err` → `timeout_err`=0 and `err_id` stays 3.
- **Simultaneous events:** with TIMEOUT=16, assert `finished` in the 16th BUSY cycle → no error. Separately, assert `clear_err` in the same cycle as an abort → `timeout_err` stays 1.
- **Stray finished:** assert `finished` while the FSM is in IDLE and in START → no state change and no `done` pulse. Dropping `req` mid-BUSY → the transfer still completes with `done` pulsed.
